// File: rtl/msx_mouse_reader.sv
// MSX mouse nibble reader: strobes the port four times per frame and publishes dx/dy/buttons.
// Define MSX_MOUSE_READER_SYNC_EN to pass data through a 2-flop synchronizer before capture.
module msx_mouse_reader #(
  parameter int unsigned SETTLE = 1024,
  parameter int unsigned GAP    = 65536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] data,
  output logic       strobe,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] buttons,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_GAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_idx;
  logic [15:0] r_settle;
  logic [19:0] r_gap;
  logic [11:0] r_nib;
  logic        r_strobe;
  logic [7:0]  r_dx;
  logic [7:0]  r_dy;
  logic [1:0]  r_btn;
  logic        r_valid;
  logic [5:0]  w_data;

`ifdef MSX_MOUSE_READER_SYNC_EN
  logic [5:0] r_sync1;
  logic [5:0] r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= data;
      r_sync2 <= r_sync1;
    end
  end

  assign w_data = r_sync2;
`else
  assign w_data = data;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (enable) w_next = S_STEP;
      S_STEP:    w_next = S_WAIT;
      S_WAIT:    if (r_settle == 16'd1) w_next = S_CAPTURE;
      S_CAPTURE: w_next = (r_idx == 2'd3) ? S_DONE : S_STEP;
      S_DONE:    w_next = S_GAP;
      S_GAP:     if (r_gap == 20'd1) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx    <= '0;
      r_settle <= '0;
      r_gap    <= '0;
      r_nib    <= '0;
      r_strobe <= 1'b0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_btn    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable) r_idx <= '0;
        end
        S_STEP: begin
          r_strobe <= ~r_strobe;
          r_settle <= 16'(SETTLE);
        end
        S_WAIT: begin
          r_settle <= r_settle - 16'd1;
        end
        S_CAPTURE: begin
          // Last nibble goes straight to the outputs so a partial frame never publishes.
          case (r_idx)
            2'd0: r_nib[11:8] <= w_data[3:0];
            2'd1: r_nib[7:4]  <= w_data[3:0];
            2'd2: r_nib[3:0]  <= w_data[3:0];
            default: begin
              r_dx    <= r_nib[11:4];
              r_dy    <= {r_nib[3:0], w_data[3:0]};
              r_btn   <= ~w_data[5:4];
              r_valid <= 1'b1;
            end
          endcase
          if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
        end
        S_DONE: begin
          r_gap <= 20'(GAP);
        end
        S_GAP: begin
          r_gap <= r_gap - 20'd1;
        end
        default: ;
      endcase
    end
  end

  assign strobe  = r_strobe;
  assign dx      = r_dx;
  assign dy      = r_dy;
  assign buttons = r_btn;
  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);

endmodule

// File: doc/msx_mouse_reader.md
MSX_MOUSE_READER -- requirements
Module: msx_mouse_reader

Interface
REQ-001 Parameter SETTLE, default 1024: clocks waited after each strobe edge before sampling; legal range 2..65535.
REQ-002 Parameter GAP, default 65536: idle clocks between frames, so the mouse's own nibble counter times out; legal range 1..1048575.
REQ-003 clk  input  1  system clock; all logic is single-clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  request continuous polling.
REQ-006 data  input  6  port pins: [3:0] nibble (positive logic), [5:4] buttons 2/1 (active-low).
REQ-007 strobe  output  1  strobe pin driven to the mouse.
REQ-008 dx  output  8  last X delta, two's complement.
REQ-009 dy  output  8  last Y delta, two's complement.
REQ-010 buttons  output  2  last button state, active-high: [0]=~data[4], [1]=~data[5].
REQ-011 valid  output  1  one-clock pulse when dx/dy/buttons update.
REQ-012 busy  output  1  high whenever FSM not in IDLE.

Function
REQ-013 FSM states: IDLE, STEP, WAIT, CAPTURE, DONE, GAP.
REQ-014 IDLE: strobe held; enable=1 at a clock edge -> STEP with nibble index 0; enable=0 -> stay.
REQ-015 STEP (1 clock): toggle strobe, load settle counter with SETTLE -> WAIT.
REQ-016 WAIT: decrement each clock; after exactly SETTLE clocks -> CAPTURE.
REQ-017 CAPTURE (1 clock): latch data[3:0] into nibble slot index; index 3 also latches data[5:4]; index<3 -> increment, STEP; index 3 -> DONE.
REQ-018 Nibble order: dx={n0,n1}, dy={n2,n3} (X high, X low, Y high, Y low); no sign inversion.
REQ-019 Each nibble costs SETTLE+2 clocks; valid high for exactly the one clock following the 4th CAPTURE, i.e. 4*(SETTLE+2)+1 clocks after the edge where IDLE sampled enable=1; dx/dy/buttons update the same clock and hold until next DONE.
REQ-020 DONE (1 clock) -> GAP, load gap counter with GAP; GAP counts exactly GAP clocks -> IDLE.
REQ-021 Exactly 4 strobe edges per frame; strobe equals 0 in IDLE, GAP and DONE.
REQ-022 enable sampled only in IDLE; deassertion mid-frame lets the frame complete and publish, then FSM rests in IDLE.
REQ-023 Partial frames never update dx/dy/buttons.
REQ-024 Counters 16-bit (settle) and 20-bit (gap); no wrap possible within legal parameter range.

Reset
REQ-025 reset_n=0 asynchronously forces IDLE, strobe=0, dx=0, dy=0, buttons=0, valid=0, busy=0, nibble index 0, counters 0, including mid-frame.
REQ-026 After reset_n release with enable=1, first frame begins at nibble 0 on the first clock edge.

Configuration
REQ-027 Macro MSX_MOUSE_READER_SYNC_EN defined: data passes through a 2-flop synchronizer; CAPTURE uses value present at data 2 clocks earlier; timing of strobe/valid unchanged.
REQ-028 Macro undefined: CAPTURE samples data directly at that edge; no synchronizer flops.

Verification
REQ-029 SETTLE=4, GAP=8, enable=1, model mouse presents 3,C,F,E per strobe edge, data[5:4]=2'b10 -> dx=8'h3C, dy=8'hFE, buttons=2'b01, valid one clock at cycle 25.
REQ-030 Free-running enable=1: count strobe edges -> exactly 4 per frame, strobe=0 between frames, next frame's first edge no earlier than GAP+1 clocks after valid.
REQ-031 Drop enable during nibble 1 WAIT -> frame completes with valid, then strobe stays 0 and busy=0 indefinitely.
REQ-032 Assert reset_n=0 during nibble 2 WAIT -> same-cycle strobe=0, dx=dy=0, valid=0, busy=0; after release, next frame reads from nibble 0 and publishes fresh values.
REQ-033 Change data[3:0] one clock before a CAPTURE -> new value captured without MSX_MOUSE_READER_SYNC_EN, old value captured with it.
